// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encoding and the load protocol constants
// that the debug unit and the host-side loader script also rely on.
package program_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0]  START_BYTE = 8'h01;
   localparam logic [15:0] HALT_WORD  = 16'h0000;

endpackage

// File: rtl/program_loader.sv
// Boot-time program loader: assembles little-endian byte pairs from the UART
// into instruction words and writes them to consecutive program memory addresses.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_done,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_we,
   output logic              o_busy,
   output logic              o_cpu_reset,
   output logic              o_done,
   output logic [ADDR_W:0]   o_word_count
);

   state_t            state;
   logic [7:0]        low_byte;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] word;

   assign word = {i_rx_data, low_byte};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= IDLE;
         ptr          <= '0;
         o_addr       <= '0;
         o_data       <= '0;
         o_we         <= 1'b0;
         o_word_count <= '0;
         o_busy       <= 1'b1;
         o_cpu_reset  <= 1'b1;
         o_done       <= 1'b0;
      end else begin
         o_we <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_done && (i_rx_data == START_BYTE)) begin
                  state <= LOW;
               end
            end
            LOW: begin
               if (i_rx_done) begin
                  low_byte <= i_rx_data;
                  state    <= HIGH;
               end
            end
            HIGH: begin
               if (i_rx_done) begin
                  o_data       <= word;
                  o_addr       <= ptr;
                  o_we         <= 1'b1;
                  ptr          <= ptr + 1'b1;
                  o_word_count <= o_word_count + 1'b1;
                  // A full memory ends the load just like HALT, so ptr never wraps in use.
                  if ((word == HALT_WORD) || (ptr == '1)) begin
                     state       <= DONE;
                     o_busy      <= 1'b0;
                     o_cpu_reset <= 1'b0;
                     o_done      <= 1'b1;
                  end else begin
                     state <= LOW;
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Sequences the program memory after reset: receives the program as a byte stream from the UART receiver, assembles 16-bit instruction words, and writes them to consecutive program memory addresses.
Holds the CPU in reset for the whole load. Releases the CPU once a HALT word is stored or the memory is full.
Sits between the UART RX and the program memory write port. Its busy output selects the address source, loader or CPU PC, on the program memory address mux in the top level.

Parameters:
ADDR_W, 11, program memory address width
DATA_W, 16, instruction word width, fixed at 2 bytes
START_BYTE, 8'h01, command byte that begins a load
HALT_WORD, 16'h0000, instruction word that terminates the load

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  byte from the UART receiver, valid when i_rx_done is high
i_rx_done  in  1  single-cycle pulse, one received byte
o_addr  out  ADDR_W  program memory write address
o_data  out  DATA_W  program memory write data
o_we  out  1  program memory write enable, single-cycle pulse
o_busy  out  1  high while the loader owns the program memory port (address mux select)
o_cpu_reset  out  1  reset to the CPU, high until the load completes
o_done  out  1  load complete, sticky until i_reset
o_word_count  out  ADDR_W+1  number of words written

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset and overrides everything, including a load in progress.
- Reset values:
  - state = IDLE, o_addr = 0, o_data = 0, o_we = 0, o_word_count = 0
  - o_busy = 1, o_cpu_reset = 1, o_done = 0
- All outputs are registered. Program memory samples on the falling edge, so o_addr, o_data and o_we are stable half a cycle before the write.
- States:
  - IDLE: an i_rx_done byte equal to START_BYTE goes to LOW. Any other byte is ignored.
  - LOW: an i_rx_done byte is latched as the low byte; go to HIGH.
  - HIGH: an i_rx_done byte completes the word {byte, low}. On the next edge:
    - o_data = word, o_addr = write pointer, o_we = 1 for exactly one cycle.
    - The write pointer and o_word_count increment.
    - Next state is DONE if word == HALT_WORD or the pointer was 2^ADDR_W-1; otherwise LOW.
  - DONE: o_busy = 0, o_cpu_reset = 0, o_done = 1. All RX bytes are ignored and no further writes occur. DONE is left only via i_reset.
- Byte order: little-endian, low byte first.
- Latency: o_we asserts 1 cycle after the i_rx_done carrying the high byte.
- On the final word, o_we, o_done, o_busy falling and o_cpu_reset falling all change on the same edge. The CPU leaves reset the cycle after the final write edge.
- There is no idle cycle between words. An i_rx_done in the cycle o_we is high is accepted as the next low byte.
- Outside DONE, o_busy = 1 and o_cpu_reset = 1.
- Write pointer:
  - ADDR_W bits; it never wraps in use, because a full memory forces DONE.
  - o_word_count is ADDR_W+1 bits so it can reach 2048.
  - o_addr holds its last value after DONE.
- The HALT word itself is written to memory before DONE.
- Reset mid-load: a partially assembled word is discarded with no write, the pointer returns to 0, and a new START_BYTE is required.
- i_rx_done held high for more than one cycle counts as one byte per cycle. The UART guarantees single-cycle pulses.

Decomposition:
- Shared package/header:
  - state encoding (IDLE, LOW, HIGH, DONE, 2 bits)
  - START_BYTE and HALT_WORD constants, shared with the debug unit and the host-side loader script
- No sub-module. A single FSM with a byte latch and the pointer counter is sufficient.
- The address/enable mux onto the program memory stays in the CPU top, driven by o_busy.

Test Plan:
1. Assert i_reset 3 cycles -> o_we = 0, o_addr = 0, o_word_count = 0, o_busy = 1, o_cpu_reset = 1, o_done = 0.
2. Bytes 01, 34, 12, 00, 00 ->
   - write 16'h1234 at addr 0
   - write 16'h0000 at addr 1
   - o_done = 1, o_cpu_reset = 0 on the same edge as the second o_we
   - o_word_count = 2
3. Bytes 55, AA, then 01, 78, 56, 00, 00 -> no write before the 01; 16'h5678 written at addr 0; HALT written at 1.
4. START_BYTE then 2048 nonzero words -> last write at addr 2047, o_done = 1, o_word_count = 2048, no write to addr 0 after the final word.
5. 01, 34, 12, 78, then i_reset, then 01, CD, AB, 00, 00 ->
   - 16'h1234 written at addr 0 before the reset
   - no write of the partial word
   - 16'hABCD written at addr 0 after the reset, HALT written at 1
6. After DONE, send 01, 11, 22 -> no o_we, outputs unchanged. Back-to-back words with i_rx_done on consecutive cycles -> every word written, none dropped.
